// File: rtl/stopwatch_ctrl.sv
// MM:SS BCD stopwatch sequencer: tick prescaler, cascaded up/down digit stepping and IDLE/RUN/PAUSE/DONE control.
// Optional lap capture register is built only when LAP_EN is defined.
module stopwatch_ctrl #(
   parameter int unsigned TICK_DIV = 50000000,
   parameter int unsigned STEP     = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start_stop,
   input  logic        clear,
   input  logic        load,
   input  logic [15:0] load_val,
   input  logic        dir,
   output logic [15:0] time_bcd,
   output logic        running,
   output logic        done,
   output logic        rollover
`ifdef LAP_EN
   ,
   input  logic        lap,
   output logic [15:0] lap_bcd
`endif
);

   localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
   localparam logic [PW-1:0] PRESC_ONE = PW'(1);
   localparam logic [4:0]    STEP5     = 5'(STEP);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   state_t        state_q, state_d;
   logic [15:0]   time_q, time_d;
   logic [PW-1:0] presc_q, presc_d;
   logic          rollover_q, rollover_d;
   logic          running_q, done_q;
   logic [16:0]   step_up_s, step_dn_s;

   function automatic logic [3:0] sat_digit(input logic [3:0] d, input logic [3:0] lim);
      logic [3:0] r;
      if (d > lim) begin
         r = lim;
      end else begin
         r = d;
      end
      return r;
   endfunction

   function automatic logic [15:0] sat_bcd(input logic [15:0] v);
      return {sat_digit(v[15:12], 4'd5), sat_digit(v[11:8], 4'd9),
              sat_digit(v[7:4], 4'd5), sat_digit(v[3:0], 4'd9)};
   endfunction

   // Returns {wrap_past_59_59, stepped_time}
   function automatic logic [16:0] bcd_step_up(input logic [15:0] t);
      logic [4:0] s0, s1, s2, s3;
      logic       c0, c1, c2, c3;
      s0 = {1'b0, t[3:0]} + STEP5;
      if (s0 >= 5'd10) begin
         s0 = s0 - 5'd10;
         c0 = 1'b1;
      end else begin
         c0 = 1'b0;
      end
      s1 = {1'b0, t[7:4]} + {4'd0, c0};
      if (s1 >= 5'd6) begin
         s1 = 5'd0;
         c1 = 1'b1;
      end else begin
         c1 = 1'b0;
      end
      s2 = {1'b0, t[11:8]} + {4'd0, c1};
      if (s2 >= 5'd10) begin
         s2 = 5'd0;
         c2 = 1'b1;
      end else begin
         c2 = 1'b0;
      end
      s3 = {1'b0, t[15:12]} + {4'd0, c2};
      if (s3 >= 5'd6) begin
         s3 = 5'd0;
         c3 = 1'b1;
      end else begin
         c3 = 1'b0;
      end
      return {c3, s3[3:0], s2[3:0], s1[3:0], s0[3:0]};
   endfunction

   // Returns {borrow_out_of_min_tens, stepped_time}
   function automatic logic [16:0] bcd_step_down(input logic [15:0] t);
      logic [4:0] s0;
      logic [3:0] d1, d2, d3;
      logic       b0, b1, b2, b3;
      if ({1'b0, t[3:0]} < STEP5) begin
         s0 = {1'b0, t[3:0]} + 5'd10 - STEP5;
         b0 = 1'b1;
      end else begin
         s0 = {1'b0, t[3:0]} - STEP5;
         b0 = 1'b0;
      end
      if (!b0) begin
         d1 = t[7:4];
         b1 = 1'b0;
      end else if (t[7:4] == 4'd0) begin
         d1 = 4'd5;
         b1 = 1'b1;
      end else begin
         d1 = t[7:4] - 4'd1;
         b1 = 1'b0;
      end
      if (!b1) begin
         d2 = t[11:8];
         b2 = 1'b0;
      end else if (t[11:8] == 4'd0) begin
         d2 = 4'd9;
         b2 = 1'b1;
      end else begin
         d2 = t[11:8] - 4'd1;
         b2 = 1'b0;
      end
      if (!b2) begin
         d3 = t[15:12];
         b3 = 1'b0;
      end else if (t[15:12] == 4'd0) begin
         d3 = 4'd5;
         b3 = 1'b1;
      end else begin
         d3 = t[15:12] - 4'd1;
         b3 = 1'b0;
      end
      return {b3, d3, d2, d1, s0[3:0]};
   endfunction

   // Command decode, prescaler and digit stepping; a command edge in RUN suppresses the tick
   always_comb begin
      state_d    = state_q;
      time_d     = time_q;
      presc_d    = presc_q;
      rollover_d = 1'b0;
      step_up_s  = bcd_step_up(time_q);
      step_dn_s  = bcd_step_down(time_q);
      if (clear) begin
         state_d = ST_IDLE;
         time_d  = 16'd0;
         presc_d = '0;
      end else if (load && (state_q != ST_RUN)) begin
         state_d = ST_IDLE;
         time_d  = sat_bcd(load_val);
         presc_d = '0;
      end else if (start_stop && (state_q != ST_DONE)) begin
         case (state_q)
            ST_RUN: begin
               state_d = ST_PAUSE;
            end
            ST_IDLE, ST_PAUSE: begin
               if (dir && (time_q == 16'd0)) begin
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_RUN;
               end
            end
            default: begin
               state_d = state_q;
            end
         endcase
      end else if (state_q == ST_RUN) begin
         if (presc_q == PRESC_MAX) begin
            presc_d = '0;
            if (!dir) begin
               time_d     = step_up_s[15:0];
               rollover_d = step_up_s[16];
            end else if (step_dn_s[16] || (step_dn_s[15:0] == 16'd0)) begin
               time_d  = 16'd0;
               state_d = ST_DONE;
            end else begin
               time_d = step_dn_s[15:0];
            end
         end else begin
            presc_d = presc_q + PRESC_ONE;
         end
      end else begin
         presc_d = presc_q;
      end
   end

   // State, time, prescaler and status flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         time_q     <= 16'd0;
         presc_q    <= '0;
         rollover_q <= 1'b0;
         running_q  <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         time_q     <= time_d;
         presc_q    <= presc_d;
         rollover_q <= rollover_d;
         running_q  <= (state_d == ST_RUN);
         done_q     <= (state_d == ST_DONE);
      end
   end

   assign time_bcd = time_q;
   assign running  = running_q;
   assign done     = done_q;
   assign rollover = rollover_q;

`ifdef LAP_EN
   logic [15:0] lap_q, lap_d;

   // Lap snapshot takes the post-edge time so a coincident tick is included
   always_comb begin
      lap_d = lap_q;
      if (clear) begin
         lap_d = 16'd0;
      end else if (lap && (state_q == ST_RUN)) begin
         lap_d = time_d;
      end else begin
         lap_d = lap_q;
      end
   end

   // Lap register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lap_q <= 16'd0;
      end else begin
         lap_q <= lap_d;
      end
   end

   assign lap_bcd = lap_q;
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench: two stopwatch instances (STEP=1 and STEP=2, TICK_DIV=4) share stimulus;
// expectations are queued with a target cycle and checked by a negedge monitor.
module tb_stopwatch_ctrl;

   logic        clk;
   logic        rst_n;
   logic        start_stop, clear, load, dir;
   logic [15:0] load_val;
   logic [15:0] t1, t2;
   logic        r1, r2, d1, d2, ro1, ro2;
`ifdef LAP_EN
   logic        lap;
   logic [15:0] lap1, lap2;
`endif

   int cyc = 0;
   int applied = 0;
   int miscompares = 0;

   typedef struct {
      string       name;
      int          sel;
      int          at;
      logic [15:0] t;
      logic        r;
      logic        d;
      logic        ro;
   } exp_t;

   exp_t sb[$];

   stopwatch_ctrl #(.TICK_DIV(4), .STEP(1)) u1 (
      .clk(clk), .rst_n(rst_n), .start_stop(start_stop), .clear(clear), .load(load),
      .load_val(load_val), .dir(dir), .time_bcd(t1), .running(r1), .done(d1), .rollover(ro1)
`ifdef LAP_EN
      , .lap(lap), .lap_bcd(lap1)
`endif
   );

   stopwatch_ctrl #(.TICK_DIV(4), .STEP(2)) u2 (
      .clk(clk), .rst_n(rst_n), .start_stop(start_stop), .clear(clear), .load(load),
      .load_val(load_val), .dir(dir), .time_bcd(t2), .running(r2), .done(d2), .rollover(ro2)
`ifdef LAP_EN
      , .lap(lap), .lap_bcd(lap2)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: compare every expectation whose target cycle has arrived
   always @(negedge clk) begin
      logic [15:0] at_t;
      logic        at_r, at_d, at_ro;
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].at <= cyc) begin
            case (sb[i].sel)
               1: begin at_t = t1; at_r = r1; at_d = d1; at_ro = ro1; end
               2: begin at_t = t2; at_r = r2; at_d = d2; at_ro = ro2; end
               default: begin at_t = 16'hxxxx; at_r = 1'bx; at_d = 1'bx; at_ro = 1'bx; end
            endcase
            applied++;
            if (sb[i].at < cyc) begin
               miscompares++;
               $display("FAIL %s dut%0d: expectation for cycle %0d missed (now %0d)",
                        sb[i].name, sb[i].sel, sb[i].at, cyc);
            end else if (at_t !== sb[i].t || at_r !== sb[i].r || at_d !== sb[i].d || at_ro !== sb[i].ro) begin
               miscompares++;
               $display("FAIL %s dut%0d cyc %0d: got time=%h run=%b done=%b roll=%b, want time=%h run=%b done=%b roll=%b",
                        sb[i].name, sb[i].sel, cyc, at_t, at_r, at_d, at_ro,
                        sb[i].t, sb[i].r, sb[i].d, sb[i].ro);
            end
            sb.delete(i);
         end
      end
   end

   task automatic expect_at(input string nm, input int sel, input int dly, input logic [15:0] t,
                            input logic r, input logic d, input logic ro);
      exp_t e;
      e.name = nm; e.sel = sel; e.at = cyc + dly; e.t = t; e.r = r; e.d = d; e.ro = ro;
      sb.push_back(e);
   endtask

   task automatic step_clk(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse_ss();
      start_stop = 1'b1; step_clk(1); start_stop = 1'b0;
   endtask

   task automatic pulse_clr();
      clear = 1'b1; step_clk(1); clear = 1'b0;
   endtask

   task automatic pulse_load(input logic [15:0] v);
      load_val = v; load = 1'b1; step_clk(1); load = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; start_stop = 1'b0; clear = 1'b0; load = 1'b0; dir = 1'b0; load_val = 16'h0000;
`ifdef LAP_EN
      lap = 1'b0;
`endif
      step_clk(2);
      expect_at("reset", 1, 0, 16'h0000, 1'b0, 1'b0, 1'b0);
      expect_at("reset", 2, 0, 16'h0000, 1'b0, 1'b0, 1'b0);
      step_clk(1);
      rst_n = 1'b1;
      step_clk(1);

      // Basic up count, STEP=1
      pulse_ss();
      expect_at("run_entry", 1, 0, 16'h0000, 1'b1, 1'b0, 1'b0);
      expect_at("pre_tick", 1, 3, 16'h0000, 1'b1, 1'b0, 1'b0);
      expect_at("tick1", 1, 4, 16'h0001, 1'b1, 1'b0, 1'b0);
      expect_at("tick2", 1, 8, 16'h0002, 1'b1, 1'b0, 1'b0);
      step_clk(8);
      pulse_clr();
      expect_at("clear_run", 1, 0, 16'h0000, 1'b0, 1'b0, 1'b0);

      // Wrap past 59:59
      pulse_load(16'h5958);
      expect_at("load_5958", 1, 0, 16'h5958, 1'b0, 1'b0, 1'b0);
      pulse_ss();
      expect_at("to_5959", 1, 4, 16'h5959, 1'b1, 1'b0, 1'b0);
      expect_at("wrap", 1, 8, 16'h0000, 1'b1, 1'b0, 1'b1);
      expect_at("wrap_pulse_end", 1, 9, 16'h0000, 1'b1, 1'b0, 1'b0);
      step_clk(9);
      pulse_clr();

      // Cascades: up and down with STEP=2 and STEP=1
      pulse_load(16'h0109);
      dir = 1'b0;
      pulse_ss();
      expect_at("up_0109", 2, 4, 16'h0111, 1'b1, 1'b0, 1'b0);
      expect_at("up_0109", 1, 4, 16'h0110, 1'b1, 1'b0, 1'b0);
      step_clk(4);
      pulse_clr();
      pulse_load(16'h0109);
      dir = 1'b1;
      pulse_ss();
      expect_at("dn_0109", 2, 4, 16'h0107, 1'b1, 1'b0, 1'b0);
      expect_at("dn_0109", 1, 4, 16'h0108, 1'b1, 1'b0, 1'b0);
      step_clk(4);
      pulse_clr();
      pulse_load(16'h0100);
      pulse_ss();
      expect_at("dn_0100", 2, 4, 16'h0058, 1'b1, 1'b0, 1'b0);
      expect_at("dn_0100", 1, 4, 16'h0059, 1'b1, 1'b0, 1'b0);
      step_clk(4);
      pulse_clr();

      // Down past zero clamps and finishes
      pulse_load(16'h0001);
      pulse_ss();
      expect_at("pre_clamp", 2, 3, 16'h0001, 1'b1, 1'b0, 1'b0);
      expect_at("clamp", 2, 4, 16'h0000, 1'b0, 1'b1, 1'b0);
      expect_at("exact_zero", 1, 4, 16'h0000, 1'b0, 1'b1, 1'b0);
      step_clk(4);
      pulse_ss();
      expect_at("done_ignore_ss", 2, 0, 16'h0000, 1'b0, 1'b1, 1'b0);
      expect_at("done_hold", 2, 4, 16'h0000, 1'b0, 1'b1, 1'b0);
      step_clk(4);
      pulse_clr();
      expect_at("done_clear", 2, 0, 16'h0000, 1'b0, 1'b0, 1'b0);

      // Pause holds the prescaler phase
      dir = 1'b0;
      pulse_ss();
      step_clk(2);
      pulse_ss();
      expect_at("pause", 1, 0, 16'h0000, 1'b0, 1'b0, 1'b0);
      expect_at("pause_hold", 1, 10, 16'h0000, 1'b0, 1'b0, 1'b0);
      step_clk(10);
      pulse_ss();
      expect_at("resume", 1, 1, 16'h0000, 1'b1, 1'b0, 1'b0);
      expect_at("resume_step", 1, 2, 16'h0001, 1'b1, 1'b0, 1'b0);
      step_clk(2);
      clear = 1'b1; load = 1'b1; start_stop = 1'b1; load_val = 16'h1234;
      step_clk(1);
      clear = 1'b0; load = 1'b0; start_stop = 1'b0;
      expect_at("cmd_priority", 1, 0, 16'h0000, 1'b0, 1'b0, 1'b0);
      expect_at("cmd_priority", 2, 0, 16'h0000, 1'b0, 1'b0, 1'b0);

      // Load saturation, down-start at zero
      pulse_load(16'hAB7C);
      expect_at("load_sat", 1, 0, 16'h5959, 1'b0, 1'b0, 1'b0);
      pulse_clr();
      dir = 1'b1;
      pulse_ss();
      expect_at("dn_start_zero", 1, 0, 16'h0000, 1'b0, 1'b1, 1'b0);
      expect_at("dn_start_nostep", 1, 4, 16'h0000, 1'b0, 1'b1, 1'b0);
      step_clk(4);

      // Async reset mid-RUN
      pulse_clr();
      dir = 1'b0;
      pulse_load(16'h0200);
      pulse_ss();
      expect_at("pre_reset_step", 1, 4, 16'h0201, 1'b1, 1'b0, 1'b0);
      step_clk(5);
      rst_n = 1'b0;
      expect_at("async_reset", 1, 0, 16'h0000, 1'b0, 1'b0, 1'b0);
      expect_at("async_reset", 2, 0, 16'h0000, 1'b0, 1'b0, 1'b0);
      step_clk(1);
      rst_n = 1'b1;
      step_clk(2);

      while (sb.size() != 0) begin
         applied++;
         miscompares++;
         $display("FAIL %s dut%0d: expectation for cycle %0d never checked",
                  sb[0].name, sb[0].sel, sb[0].at);
         sb.delete(0);
      end
      $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
      $finish;
   end

endmodule
